// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the cache's 256-bit line port and a 64-bit burst DRAM.
// A line fill is collected as BEATS inbound beats. A writeback is sent as BEATS
// outbound beats. In both directions the low-order beat goes first.
// The cache sees a single-cycle resp_o pulse once the whole line has moved.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a request; a write request wins over a read request
// READ  | read_o high; each resp_i beat is stored into line_o at slot cnt
// WRITE | write_o high; burst_o shows buffer slot cnt; resp_i retires a beat
// DONE  | resp_o high for one cycle, then back to IDLE unconditionally
module cacheline_adaptor #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic [ADDR_WIDTH-1:0]  address_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic [ADDR_WIDTH-1:0]  address_o,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   localparam int BEATS   = LINE_WIDTH / BURST_WIDTH;
   localparam int CNT_W   = $clog2(BEATS);
   localparam int LSB_W   = $clog2(LINE_WIDTH);
   localparam int BEAT_SH = $clog2(BURST_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   // The mask clears the byte offset within a line, so address_o is line aligned.
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [LINE_WIDTH-1:0]   wbuf;
   logic [LSB_W-1:0]        beat_lsb;

   // Bit offset of the current beat within the line (BURST_WIDTH is a power of two).
   assign beat_lsb = {cnt, {BEAT_SH{1'b0}}};

   // The outbound beat is read straight from the write buffer at the current slot.
   assign burst_o = wbuf[beat_lsb +: BURST_WIDTH];

   // Transfer sequencer with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         resp_o    <= 1'b0;
         address_o <= '0;
         line_o    <= '0;
         wbuf      <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_o <= 1'b0;
               cnt    <= '0;
               if (write_i) begin
                  address_o <= address_i & ADDR_MASK;
                  wbuf      <= line_i;
                  write_o   <= 1'b1;
                  state     <= WRITE;
               end else if (read_i) begin
                  address_o <= address_i & ADDR_MASK;
                  read_o    <= 1'b1;
                  state     <= READ;
               end
            end
            READ: begin
               if (resp_i) begin
                  line_o[beat_lsb +: BURST_WIDTH] <= burst_i;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_BEAT) begin
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            WRITE: begin
               if (resp_i) begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_BEAT) begin
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               resp_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache controller, between the cache's 256-bit line port and the 64-bit burst DRAM.
- Converts one line read (fill) into 4 inbound beats assembled into a line.
- Converts one line write (writeback) into 4 outbound beats.
- Presents a single-cycle line-level handshake back to the cache.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BURST_WIDTH, 64, DRAM beat width in bits; BEATS = LINE_WIDTH/BURST_WIDTH (4).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- line_i  in  LINE_WIDTH  line to write back, from cache.
- line_o  out  LINE_WIDTH  assembled fill line, to cache.
- address_i  in  ADDR_WIDTH  line address from cache.
- read_i  in  1  cache requests a line fill.
- write_i  in  1  cache requests a line writeback.
- resp_o  out  1  line transfer complete, one-cycle pulse.
- burst_i  in  BURST_WIDTH  read beat from DRAM.
- burst_o  out  BURST_WIDTH  write beat to DRAM.
- address_o  out  ADDR_WIDTH  line-aligned DRAM address.
- read_o  out  1  DRAM read request.
- write_o  out  1  DRAM write request.
- resp_i  in  1  DRAM beat valid/accepted, one beat per high cycle.

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE and the beat counter goes to 0.
  - read_o, write_o and resp_o are 0; address_o, burst_o and line_o registers are 0.
  - Reset mid-burst abandons the transfer immediately. No resp_o is generated, and beats already captured are discarded.
- States: IDLE, READ, WRITE, DONE. The beat counter cnt is log2(BEATS) bits wide.
- IDLE:
  - read_o, write_o and resp_o are 0.
  - If write_i is high: latch address_o = {address_i[ADDR_WIDTH-1:5], 5'b0} (5 = log2(LINE_WIDTH/8)), latch line_i into the write buffer, set cnt=0, go to WRITE.
  - Else if read_i is high: latch the aligned address, set cnt=0, go to READ.
  - write_i and read_i both high: write wins (writeback before fill); the read is served only if still asserted on return to IDLE.
  - resp_i while in IDLE is ignored.
- READ:
  - read_o=1 for the whole state.
  - On each cycle with resp_i=1: line_o[cnt*BURST_WIDTH +: BURST_WIDTH] <= burst_i, and cnt increments.
  - On the beat where cnt==BEATS-1: go to DONE. cnt wraps to 0.
  - resp_i low cycles (gaps) stall the transfer with no state change.
- WRITE:
  - write_o=1 for the whole state; burst_o = buffer[cnt*BURST_WIDTH +: BURST_WIDTH], combinational from cnt.
  - Each resp_i=1 cycle retires the current beat and increments cnt.
  - On the beat where cnt==BEATS-1: go to DONE.
  - Beat order is low bits first in both directions.
- DONE:
  - resp_o=1 for exactly one cycle; read_o and write_o are 0; next state is IDLE unconditionally.
  - The cache deasserts read_i/write_i in response to resp_o.
  - A request still high in the IDLE cycle that follows is treated as a new request.
- Stability rules:
  - line_o holds its last assembled value until the next READ overwrites it, and is valid whenever resp_o=1 after a read.
  - address_i and line_i are sampled only on the IDLE→READ/WRITE transition; later changes have no effect.
  - address_o stays stable throughout READ and WRITE.
- Latency: request high in IDLE at cycle T gives read_o/write_o high from T+1. With 4 back-to-back resp_i beats at T+1..T+4, resp_o is high at T+5.

Test Plan:
- Read fill, no gaps: read_i=1, address_i=0x0000_1234. Bench checks address_o=0x0000_1220 and read_o=1. DRAM returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on 4 consecutive cycles. Then resp_o pulses one cycle and line_o = {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Writeback with gaps: write_i=1, line_i = {D3,D2,D1,D0}, resp_i pattern 1,0,1,0,0,1,1. Bench checks burst_o steps D0→D1→D2→D3 only on resp_i edges, write_o high throughout, and resp_o exactly once, on the cycle after the 4th beat.
- Simultaneous request: read_i=write_i=1. Bench checks WRITE is entered first (write_o=1, read_o=0). After that resp_o, with read_i still high, READ starts on the next IDLE cycle.
- Mid-burst reset: rst=1 after 2 read beats. Bench checks read_o=0 and resp_o=0 next cycle. A fresh read then completes with all 4 new beats correct and no stale data.
- Input stability: change address_i/line_i during WRITE. Bench checks address_o and burst_o still reflect the values latched at request.
- Spurious resp_i in IDLE for 3 cycles: bench checks no state change, cnt=0, and resp_o=0.
